// File: rtl/quad_ctrl_pkg.sv
// Shared defaults and FSM encoding for the quadrature velocity sampler.
package quad_ctrl_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int PERIOD_W_DEF = 16;
    localparam int MIN_PERIOD   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/sample_timer.sv
// Sample-period timer: latches the period at each wrap, clamps it to at least
// MIN_PERIOD and fires tick on the last cycle of the period.
module sample_timer
    import quad_ctrl_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] last;

    always_comb begin
        last = (period_q < MIN_P) ? (MIN_P - PERIOD_W'(1)) : (period_q - PERIOD_W'(1));
        tick = !hold && (timer == last);
    end

    // While held the timer sits at 0, which counts as a wrap point for the period latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer    <= '0;
            period_q <= '0;
        end else if (hold || tick) begin
            timer    <= '0;
            period_q <= period;
        end else begin
            timer    <= timer + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/quad_velocity_sampler.sv
// Samples the quadrature position count every period and emits the signed
// count difference over valid/ready; also sequences counter zeroing.
module quad_velocity_sampler
    import quad_ctrl_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int PERIOD_W   = PERIOD_W_DEF,
    parameter int CLR_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [PERIOD_W-1:0]     period,
    input  logic [WIDTH-1:0]        count_in,
    input  logic                    zero_req,
    output logic                    cnt_clr,
    output logic signed [WIDTH-1:0] vel_out,
    output logic                    vel_valid,
    input  logic                    vel_ready,
    output logic                    overrun,
    input  logic                    ovr_clr
);

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    function automatic logic signed [WIDTH-1:0] wrap_delta(input logic [WIDTH-1:0] cur,
                                                           input logic [WIDTH-1:0] old);
        return signed'(cur - old);
    endfunction

    state_t                   state, state_nxt;
    logic [CW-1:0]            clr_cnt;
    logic                     clr_done;
    logic                     timer_hold;
    logic                     tick;
    logic [WIDTH-1:0]         prev;
    logic                     primed;
    logic                     vld_p0;
    logic signed [WIDTH-1:0]  delta_p0;
    logic                     xfer;

    // A zero request or en drop in RUN holds the timer, so the tick of that cycle is lost.
    assign timer_hold = (state != RUN) || zero_req || !en;
    assign clr_done   = (clr_cnt == CW'(CLR_CYCLES - 1));

    sample_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .hold   (timer_hold),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (zero_req) state_nxt = CLEAR;
                     else if (en)  state_nxt = RUN;
            RUN:     if (zero_req) state_nxt = CLEAR;
                     else if (!en) state_nxt = IDLE;
            CLEAR:   if (clr_done) state_nxt = en ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
            cnt_clr <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == CLEAR && !clr_done) ? clr_cnt + CW'(1) : '0;
            cnt_clr <= (state_nxt == CLEAR);
        end
    end

    // Stage p0: tick strobe and raw difference against the previous sample.
    assign vld_p0   = tick && primed;
    assign delta_p0 = wrap_delta(count_in, prev);
    assign xfer     = vel_valid && vel_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev   <= '0;
            primed <= 1'b0;
        end else if (state == CLEAR) begin
            prev   <= '0;
            primed <= 1'b0;
        end else if (state == IDLE) begin
            primed <= 1'b0;
        end else if (tick) begin
            prev   <= count_in;
            primed <= 1'b1;
        end
    end

    // Stage p1: registered output with overwrite-on-overrun semantics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vel_out   <= '0;
            vel_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (vld_p0)
                vel_out <= delta_p0;
            if (vld_p0)
                vel_valid <= 1'b1;
            else if (xfer)
                vel_valid <= 1'b0;
            if (ovr_clr)
                overrun <= 1'b0;
            else if (vld_p0 && vel_valid && !vel_ready)
                overrun <= 1'b1;
        end
    end

endmodule
